deserializer: RTL

//  Receive-side counterpart of the PHY serializer: samples one serial bit per qualified clock, MSB first,
//  and rebuilds a WIDTH-bit block (default 130 = 2-bit sync header + 128-bit payload).

---
 rtl/phy_pkg.sv | 19 +
 rtl/deserializer_lock_tracker.sv | 37 +++
 rtl/deserializer.sv | 115 +++++++++++
 3 files changed

// File: rtl/phy_pkg.sv
// Shared PHY definitions: deserializer FSM states, sync header codes and the default block width.
package phy_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DRAIN
    } deser_state_t;

    localparam logic [1:0] SYNC_DATA = 2'b10;
    localparam logic [1:0] SYNC_OS   = 2'b01;
    localparam int         BLK_WIDTH = 130;

    // Only 01 and 10 are legal sync headers; 00 and 11 indicate misalignment or corruption.
    function automatic logic hdr_is_good(input logic [1:0] hdr);
        return (hdr == SYNC_DATA) || (hdr == SYNC_OS);
    endfunction

endpackage

// File: rtl/deserializer_lock_tracker.sv
// Block lock tracker: counts consecutive good sync headers and declares lock at LOCK_CNT.
module block_lock_tracker #(
    parameter int LOCK_CNT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic hdr_valid,
    input  logic hdr_good,
    output logic locked
);

    logic [3:0] good_cnt_q, good_cnt_d;
    logic       locked_q;

    always_comb begin
        good_cnt_d = good_cnt_q;
        if (hdr_valid) begin
            if (!hdr_good)
                good_cnt_d = '0;
            else if (good_cnt_q != 4'(LOCK_CNT))
                good_cnt_d = good_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            good_cnt_q <= '0;
            locked_q   <= 1'b0;
        end else if (hdr_valid) begin
            good_cnt_q <= good_cnt_d;
            locked_q   <= (good_cnt_d == 4'(LOCK_CNT));
        end
    end

    assign locked = locked_q;

endmodule

// File: rtl/deserializer.sv
// Serial-to-parallel block receiver: MSB-first shift, one-cycle block strobe, sync header
// classification and block lock tracking.
module deserializer
    import phy_pkg::*;
#(
    parameter int WIDTH     = BLK_WIDTH,
    parameter bit HDR_CHECK = 1'b1,
    parameter int LOCK_CNT  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ser_in,
    input  logic             ser_valid,
    output logic [WIDTH-1:0] par_out,
    output logic             par_valid,
    output logic             blk_os,
    output logic             hdr_err,
    output logic             frm_err,
    output logic             locked,
    output logic             busy
);

    localparam int CW     = $clog2(WIDTH + 1);
    localparam int HDR_SH = (WIDTH >= 2) ? WIDTH - 2 : 0;
    localparam bit HDR_ON = HDR_CHECK && (WIDTH >= 2);

    deser_state_t     state_q;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] par_out_q;
    logic             par_valid_q, blk_os_q, hdr_err_q, frm_err_q;
    logic [1:0]       hdr_d;
    logic             hdr_good_d;
    logic             complete_d;

    // The header is taken from the block including the bit sampled this cycle.
    always_comb begin
        shift_d    = (shift_q << 1) | WIDTH'(ser_in);
        hdr_d      = 2'(shift_d >> HDR_SH);
        hdr_good_d = hdr_is_good(hdr_d);
        complete_d = ser_valid &&
                     (((state_q == IDLE) && (WIDTH == 1)) ||
                      ((state_q == SHIFT) && (cnt_q == CW'(WIDTH - 1))));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            cnt_q       <= '0;
            par_out_q   <= '0;
            par_valid_q <= 1'b0;
            blk_os_q    <= 1'b0;
            hdr_err_q   <= 1'b0;
            frm_err_q   <= 1'b0;
        end else begin
            par_valid_q <= 1'b0;
            blk_os_q    <= 1'b0;
            hdr_err_q   <= 1'b0;
            frm_err_q   <= 1'b0;
            if (complete_d) begin
                par_out_q   <= shift_d;
                par_valid_q <= 1'b1;
                blk_os_q    <= (WIDTH >= 2) && (hdr_d == SYNC_OS);
                hdr_err_q   <= HDR_ON && !hdr_good_d;
            end
            unique case (state_q)
                IDLE: begin
                    if (ser_valid) begin
                        shift_q <= shift_d;
                        cnt_q   <= CW'(1);
                        state_q <= (WIDTH == 1) ? DRAIN : SHIFT;
                    end
                end
                SHIFT: begin
                    if (ser_valid) begin
                        shift_q <= shift_d;
                        cnt_q   <= cnt_q + CW'(1);
                        if (complete_d)
                            state_q <= DRAIN;
                    end else begin
                        frm_err_q <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= IDLE;
                    end
                end
                DRAIN: begin
                    if (!ser_valid) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    block_lock_tracker #(
        .LOCK_CNT(LOCK_CNT)
    ) u_lock (
        .clk      (clk),
        .rst      (rst),
        .hdr_valid(HDR_ON && complete_d),
        .hdr_good (hdr_good_d),
        .locked   (locked)
    );

    assign par_out   = par_out_q;
    assign par_valid = par_valid_q;
    assign blk_os    = blk_os_q;
    assign hdr_err   = hdr_err_q;
    assign frm_err   = frm_err_q;
    assign busy      = (state_q != IDLE);

endmodule
